// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle data memory for the MEM stage with a stall/ack
//               handshake and a fixed per-access latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int         c_depth   = 2 ** ADDR_WIDTH;
    localparam logic [3:0] c_lat_m1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    r_is_write;
    logic [ADDR_WIDTH-1:0]   r_widx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_data;
    logic [31:0]             r_mem [0:c_depth-1];

    logic                    w_aligned;
    logic                    w_one_strobe;
    logic                    w_any_strobe;
    logic                    w_req_legal;
    logic                    w_req_illegal;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_unused_addr;

    // Requests are masked while reset is held so every output sits at its reset value.
    assign w_aligned     = (addr_i[1:0] == 2'b00);
    assign w_one_strobe  = MemRead_i ^ MemWrite_i;
    assign w_any_strobe  = MemRead_i | MemWrite_i;
    assign w_req_legal   = rst_i & w_one_strobe & w_aligned;
    assign w_req_illegal = rst_i & w_any_strobe & ~(w_one_strobe & w_aligned);
    assign w_accept      = (r_state == S_IDLE) & w_req_legal;
    assign w_access      = (r_state == S_BUSY) & (r_cnt == 4'd0);
    assign w_unused_addr = ^addr_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall_o     = 1'b0;
        ack_o       = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_legal) begin
                    stall_o     = 1'b1;
                    w_cnt_nxt   = c_lat_m1;
                    w_state_nxt = S_BUSY;
                end else if (w_req_illegal) begin
                    err_o = 1'b1;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                ack_o       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_widx     <= '0;
            r_wdata    <= 32'd0;
            r_data     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_is_write <= MemWrite_i;
                r_widx     <= addr_i[ADDR_WIDTH+1:2];
                r_wdata    <= data_i;
            end
            if (w_access && !r_is_write) begin
                r_data <= r_mem[r_widx];
            end
        end
    end

    // Storage is deliberately not reset; a reset mid-access drops r_state to IDLE, which kills the write.
    always_ff @(posedge clk_i) begin
        if (w_access && r_is_write) begin
            r_mem[r_widx] <= r_wdata;
        end
    end

    assign data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY   (4)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .MemRead_i (MemRead_i),
        .MemWrite_i(MemWrite_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .stall_o   (stall_o),
        .ack_o     (ack_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        data_i     = data;
    endtask

    // Issues a legal request in the next cycle and holds it until the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int stall_n;
        int ack_early;
        @(posedge clk_i); #1;
        drive(rd, wr, addr, data);
        #1;
        check({tag, "_stall_accept"}, {31'd0, stall_o}, 32'd1);
        check({tag, "_err_accept"}, {31'd0, err_o}, 32'd0);
        stall_n   = 0;
        ack_early = 0;
        while (stall_o === 1'b1 && stall_n < 40) begin
            stall_n++;
            if (ack_o !== 1'b0) ack_early++;
            @(posedge clk_i); #2;
        end
        check({tag, "_stall_cycles"}, 32'(stall_n), 32'd5);
        check({tag, "_ack_during_stall"}, 32'(ack_early), 32'd0);
        check({tag, "_ack_done"}, {31'd0, ack_o}, 32'd1);
    endtask

    task automatic idle(input string tag);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check({tag, "_ack_low"}, {31'd0, ack_o}, 32'd0);
        check({tag, "_stall_low"}, {31'd0, stall_o}, 32'd0);
    endtask

    task automatic illegal(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] exp_data, input string tag);
        @(posedge clk_i); #1;
        drive(rd, wr, addr, 32'h0BAD0BAD);
        #1;
        check({tag, "_err"}, {31'd0, err_o}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        check({tag, "_ack"}, {31'd0, ack_o}, 32'd0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check({tag, "_err_clear"}, {31'd0, err_o}, 32'd0);
        check({tag, "_ack_after"}, {31'd0, ack_o}, 32'd0);
        check({tag, "_stall_after"}, {31'd0, stall_o}, 32'd0);
        check({tag, "_data_hold"}, data_o, exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("por_data", data_o, 32'd0);
        check("por_stall", {31'd0, stall_o}, 32'd0);

        // Write then read, data_o must hold across the write.
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
        check("wr10_data_hold", data_o, 32'd0);
        idle("wr10_post");
        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, "rd10");
        check("rd10_data", data_o, 32'hDEAD_BEEF);
        idle("rd10_post");
        check("rd10_data_persist", data_o, 32'hDEAD_BEEF);

        // Asynchronous reset with no request: outputs clear before any clock edge.
        rst_i = 1'b0;
        #1;
        check("arst_data", data_o, 32'd0);
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_ack", {31'd0, ack_o}, 32'd0);
        check("arst_err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Back-to-back: the read goes in the IDLE cycle right after DONE.
        access(1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, "wr08");
        access(1'b1, 1'b0, 32'h0000_0008, 32'd0, "rd08_b2b");
        check("rd08_data", data_o, 32'h1111_1111);
        idle("rd08_post");

        // Illegal requests leave everything untouched.
        illegal(1'b1, 1'b0, 32'h0000_0013, 32'h1111_1111, "ill_misalign");
        illegal(1'b1, 1'b1, 32'h0000_0008, 32'h1111_1111, "ill_both");
        access(1'b1, 1'b0, 32'h0000_0008, 32'd0, "rd08_again");
        check("rd08_again_data", data_o, 32'h1111_1111);
        idle("rd08_again_post");

        // Reset in the second BUSY cycle of a write discards that write.
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, "wr20_a");
        idle("wr20_a_post");
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0002);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("wr20_b_busy_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_ack", {31'd0, ack_o}, 32'd0);
        check("midrst_data", data_o, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        access(1'b1, 1'b0, 32'h0000_0020, 32'd0, "rd20");
        check("rd20_data", data_o, 32'h0000_0001);
        idle("rd20_post");

        // Address wrap: 0x1004 aliases to 0x4 with a 10-bit word index.
        access(1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_0000, "wr1004");
        idle("wr1004_post");
        access(1'b1, 1'b0, 32'h0000_0004, 32'd0, "rd04");
        check("rd04_wrap_data", data_o, 32'hCAFE_0000);
        idle("rd04_post");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
